// File: rtl/fib_pkg.sv
// Shared encodings and constants for the fib_seq term generator.
package fib_pkg;

    localparam logic [1:0] MODE_FIB    = 2'd0;
    localparam logic [1:0] MODE_LUCAS  = 2'd1;
    localparam logic [1:0] MODE_CUSTOM = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam int unsigned LUCAS_T0 = 2;
    localparam int unsigned LUCAS_T1 = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fib_step.sv
// One recurrence step: t(k) = t(k-1) + t(k-2) with carry-out and optional clamp.
module fib_step #(
    parameter int DATA_W   = 32,
    parameter int SATURATE = 0
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sat_in,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_carry
);

    logic [DATA_W:0] w_full;

    function automatic logic [DATA_W-1:0] sat_sel(input logic [DATA_W-1:0] raw,
                                                  input logic clamp);
        return clamp ? {DATA_W{1'b1}} : raw;
    endfunction

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_carry = w_full[DATA_W];
    // Once the operation has overflowed, every later term stays clamped.
    assign o_sum   = sat_sel(w_full[DATA_W-1:0],
                             (SATURATE != 0) && (o_carry || i_sat_in));

endmodule

// File: rtl/fib_seq.sv
// Sequential Fibonacci/Lucas/custom-seed term generator, one term per clock.
module fib_seq
    import fib_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ARG_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed0,
    input  logic [DATA_W-1:0] seed1,
    input  logic [ARG_W-1:0]  arg,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              error,
    output logic              stream_valid,
    output logic [DATA_W-1:0] stream_term,
    output logic [ARG_W-1:0]  stream_idx
);

    logic              r_rst_sync;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [ARG_W-1:0]  r_k;
    logic [ARG_W-1:0]  r_n;
    logic              r_ovf;
    logic [DATA_W-1:0] r_result;
    logic              r_overflow;
    logic              r_error;
    logic [DATA_W-1:0] w_t0;
    logic [DATA_W-1:0] w_t1;
    logic [DATA_W-1:0] w_sum;
    logic              w_carry;
    logic              w_short;
    logic              w_last;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rst_sync <= 1'b0;
        else          r_rst_sync <= 1'b1;
    end

    always_comb begin
        w_t0 = '0;
        w_t1 = DATA_W'(1);
        case (mode)
            MODE_LUCAS: begin
                w_t0 = DATA_W'(LUCAS_T0);
                w_t1 = DATA_W'(LUCAS_T1);
            end
            MODE_CUSTOM: begin
                w_t0 = seed0;
                w_t1 = seed1;
            end
            default: ;
        endcase
    end

    assign w_short = (arg[ARG_W-1:1] == '0);
    assign w_last  = (r_k == r_n);

    fib_step #(
        .DATA_W   (DATA_W),
        .SATURATE (SATURATE)
    ) u_step (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sat_in (r_ovf),
        .o_sum    (w_sum),
        .o_carry  (w_carry)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = (mode == MODE_RSVD || w_short) ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (abort)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge r_rst_sync) begin
        if (!r_rst_sync) begin
            r_state    <= ST_IDLE;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Visible results load on the edge into DONE and hold until the next one.
            if (r_state == ST_IDLE && start) begin
                if (mode == MODE_RSVD) begin
                    r_result   <= '0;
                    r_overflow <= 1'b0;
                    r_error    <= 1'b1;
                end else if (w_short) begin
                    r_result   <= arg[0] ? w_t1 : w_t0;
                    r_overflow <= 1'b0;
                    r_error    <= 1'b0;
                end
            end else if (r_state == ST_CALC && !abort && w_last) begin
                r_result   <= w_sum;
                r_overflow <= r_ovf | w_carry;
                r_error    <= 1'b0;
            end
        end
    end

    // Working registers are always loaded by an accepted start before use.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_IDLE && start) begin
            r_a   <= w_t0;
            r_b   <= w_t1;
            r_k   <= ARG_W'(2);
            r_n   <= arg;
            r_ovf <= 1'b0;
        end else if (r_state == ST_CALC) begin
            r_a   <= r_b;
            r_b   <= w_sum;
            r_k   <= r_k + ARG_W'(1);
            r_ovf <= r_ovf | w_carry;
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign stream_valid = (r_state == ST_CALC);
    assign stream_term  = stream_valid ? w_sum : '0;
    assign stream_idx   = stream_valid ? r_k : '0;
    assign result       = r_result;
    assign overflow     = r_overflow;
    assign error        = r_error;

endmodule
